// File: rtl/krnl_idct_mac_pkg.sv
// krnl_idct_mac_pkg: widths, tag type and round/shift/reduce helpers for the IDCT MAC accumulator
// KRNL_IDCT_MAC_SAT_EN selects clamping instead of two's-complement wrap in reduce()
package krnl_idct_mac_pkg;
  localparam int N_TAPS = 8;
  localparam int MUL_LAT = 3;
  localparam int PROD_W = 16;
  localparam int ACC_W = PROD_W + $clog2(N_TAPS);
  localparam int SHIFT = 2;
  localparam int OUT_W = 16;
  localparam int TAP_W = $clog2(N_TAPS);
  localparam logic [1:0] CREDITS = 2'd2;
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'((1 << SHIFT) >> 1);
`ifdef KRNL_IDCT_MAC_SAT_EN
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] MINV = ~MAXV;
`endif
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;
  // one guard bit above ACC_W keeps the rounding add from wrapping
  function automatic logic signed [ACC_W:0] rnd_shift(input logic signed [ACC_W-1:0] a);
    return ($signed({a[ACC_W-1], a}) + RND) >>> SHIFT;
  endfunction
  function automatic logic [OUT_W-1:0] reduce(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] r;
    r = rnd_shift(a);
`ifdef KRNL_IDCT_MAC_SAT_EN
    return r > MAXV ? MAXV[OUT_W-1:0] : r < MINV ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
`else
    return OUT_W'(r);
`endif
  endfunction
`ifdef KRNL_IDCT_MAC_SAT_EN
  function automatic logic is_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] r;
    r = rnd_shift(a);
    return r > MAXV || r < MINV;
  endfunction
`endif
endpackage

// File: rtl/krnl_idct_mac_acc_if.sv
// krnl_idct_mac_acc_if: operand-issue handshake, product input and output valid/ready bus
interface krnl_idct_mac_acc_if;
  import krnl_idct_mac_pkg::*;
  logic issue_valid;
  logic issue_ready;
  logic [PROD_W-1:0] prod_in;
  logic [OUT_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master (output issue_valid, prod_in, out_ready, input issue_ready, out_data, out_valid);
  modport slave (input issue_valid, prod_in, out_ready, output issue_ready, out_data, out_valid);
endinterface

// File: rtl/krnl_idct_mac_obuf.sv
// krnl_idct_mac_obuf: 2-entry output FIFO with occupancy count
module krnl_idct_mac_obuf
  import krnl_idct_mac_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] dout,
  output logic empty,
  output logic [1:0] count
);
  logic [OUT_W-1:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign dout = mem[rp];
  assign empty = count == '0;
endmodule

// File: rtl/krnl_idct_mac_acc.sv
// krnl_idct_mac_acc: sums N_TAPS multiplier products per sample, rounds/reduces, buffers the result
// KRNL_IDCT_MAC_SAT_EN: clamp to OUT_W and add a sticky sat_flag output
module krnl_idct_mac_acc
  import krnl_idct_mac_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ce,
  krnl_idct_mac_acc_if.slave bus,
  output logic busy
`ifdef KRNL_IDCT_MAC_SAT_EN
  ,
  output logic sat_flag
`endif
);
  logic [TAP_W-1:0] tap;
  tag_t tags [MUL_LAT];
  tag_t tag_o;
  logic signed [ACC_W-1:0] acc, acc_next, prod_x;
  logic [1:0] reserved, count;
  logic issue, push, pop, empty, any_tag;
  logic [OUT_W-1:0] push_data;
  assign bus.issue_ready = reserved != CREDITS || tap != '0;
  assign issue = bus.issue_valid & bus.issue_ready & ce;
  assign pop = bus.out_valid & bus.out_ready;
  assign tag_o = tags[MUL_LAT-1];
  assign prod_x = {{(ACC_W - PROD_W){bus.prod_in[PROD_W-1]}}, bus.prod_in};
  assign acc_next = tag_o.first ? prod_x : acc + prod_x;
  assign push = ce & tag_o.valid & tag_o.last;
  assign push_data = reduce(acc_next);
  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) any_tag = any_tag | tags[i].valid;
  end
  assign busy = any_tag || tap != '0 || count != '0;
  // tags stall with ce exactly like the multiplier pipeline they shadow
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tap <= '0;
      acc <= '0;
      reserved <= '0;
      for (int i = 0; i < MUL_LAT; i++) tags[i] <= '0;
    end else begin
      if (issue) tap <= tap + 1'b1;
      if (ce) begin
        tags[0] <= '{valid: issue, first: issue && tap == '0, last: issue && tap == TAP_W'(N_TAPS - 1)};
        for (int i = 1; i < MUL_LAT; i++) tags[i] <= tags[i-1];
        if (tag_o.valid) acc <= acc_next;
      end
      reserved <= reserved + {1'b0, issue && tap == '0} - {1'b0, pop};
    end
`ifdef KRNL_IDCT_MAC_SAT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) sat_flag <= 1'b0;
    else if (push && is_sat(acc_next)) sat_flag <= 1'b1;
`endif
  krnl_idct_mac_obuf u_obuf (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(push_data),
    .dout(bus.out_data),
    .empty(empty),
    .count(count)
  );
  assign bus.out_valid = !empty;
endmodule

// File: tb/tb_krnl_idct_mac_acc.sv
// tb_krnl_idct_mac_acc: directed tests for the IDCT MAC accumulator with a pipelined multiplier model
module tb_krnl_idct_mac_acc;
  import krnl_idct_mac_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;
  logic busy;
`ifdef KRNL_IDCT_MAC_SAT_EN
  logic sat_flag;
`endif
  int nvec = 0;
  int nerr = 0;
  int pv [N_TAPS];
  int n;
  logic [PROD_W-1:0] op = '0;
  logic [PROD_W-1:0] pipe [MUL_LAT];
  logic [OUT_W-1:0] exp_sat;
  krnl_idct_mac_acc_if bus ();
  krnl_idct_mac_acc dut (
    .clk(clk),
    .reset(reset),
    .ce(ce),
    .bus(bus),
    .busy(busy)
`ifdef KRNL_IDCT_MAC_SAT_EN
    ,
    .sat_flag(sat_flag)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    if (ce) begin
      pipe[0] <= op;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign bus.prod_in = pipe[MUL_LAT-1];
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue_group(input int stall_at);
    int g;
    for (int i = 0; i < N_TAPS; i++) begin
      if (i == stall_at) begin
        ce = 1'b0;
        bus.issue_valid = 1'b1;
        repeat (5) step();
        ce = 1'b1;
      end
      bus.issue_valid = 1'b1;
      op = PROD_W'(pv[i]);
      g = 0;
      while (!bus.issue_ready && g < 50) begin
        step();
        g++;
      end
      step();
    end
    bus.issue_valid = 1'b0;
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      step();
      cnt++;
    end
    if (!bus.out_valid) cnt = -1;
  endtask
  task automatic test_reset();
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    nvec++; if (bus.out_data !== 16'h0000) begin nerr++; $display("FAIL reset_data: got %h want 0000", bus.out_data); end
    nvec++; if (bus.issue_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef KRNL_IDCT_MAC_SAT_EN
    nvec++; if (sat_flag !== 1'b0) begin nerr++; $display("FAIL reset_sat: got %b want 0", sat_flag); end
`endif
    reset = 1'b1;
    ce = 1'b1;
    bus.out_ready = 1'b1;
    step();
  endtask
  task automatic test_basic();
    for (int i = 0; i < N_TAPS; i++) pv[i] = 100;
    issue_group(-1);
    wait_valid(n);
    nvec++; if (n !== 3) begin nerr++; $display("FAIL basic_latency: got %0d want 3", n); end
    nvec++; if (bus.out_data !== 16'd200) begin nerr++; $display("FAIL basic_data: got %0d want 200", $signed(bus.out_data)); end
    step();
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL basic_pulse: got %b want 0", bus.out_valid); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL basic_idle: got %b want 0", busy); end
  endtask
  task automatic test_sat();
`ifdef KRNL_IDCT_MAC_SAT_EN
    exp_sat = 16'h7FFF;
`else
    exp_sat = 16'h9C40;
`endif
    for (int i = 0; i < N_TAPS; i++) pv[i] = 20000;
    issue_group(-1);
    wait_valid(n);
    nvec++; if (bus.out_data !== exp_sat) begin nerr++; $display("FAIL sat_data: got %h want %h", bus.out_data, exp_sat); end
`ifdef KRNL_IDCT_MAC_SAT_EN
    nvec++; if (sat_flag !== 1'b1) begin nerr++; $display("FAIL sat_flag: got %b want 1", sat_flag); end
`endif
    step();
  endtask
  task automatic test_round();
    pv = '{-3, 0, 0, 0, 0, 0, 0, 0};
    issue_group(-1);
    wait_valid(n);
    nvec++; if (n !== 3) begin nerr++; $display("FAIL round_latency: got %0d want 3", n); end
    nvec++; if (bus.out_data !== 16'hFFFF) begin nerr++; $display("FAIL round_data: got %h want ffff", bus.out_data); end
    step();
  endtask
  task automatic test_stall();
    pv = '{10, 20, 30, 40, 50, 60, 70, 80};
    issue_group(6);
    wait_valid(n);
    nvec++; if (n !== 3) begin nerr++; $display("FAIL stall_latency: got %0d want 3", n); end
    nvec++; if (bus.out_data !== 16'd90) begin nerr++; $display("FAIL stall_data: got %0d want 90", $signed(bus.out_data)); end
    step();
  endtask
  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < N_TAPS; i++) pv[i] = 4;
    issue_group(-1);
    for (int i = 0; i < N_TAPS; i++) pv[i] = 8;
    issue_group(-1);
    nvec++; if (bus.issue_ready !== 1'b0) begin nerr++; $display("FAIL bp_block: got %b want 0", bus.issue_ready); end
    bus.issue_valid = 1'b1;
    op = 16'd12;
    repeat (6) step();
    nvec++; if (bus.issue_ready !== 1'b0) begin nerr++; $display("FAIL bp_hold: got %b want 0", bus.issue_ready); end
    nvec++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL bp_valid: got %b want 1", bus.out_valid); end
    nvec++; if (bus.out_data !== 16'd8) begin nerr++; $display("FAIL bp_first: got %0d want 8", $signed(bus.out_data)); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL bp_busy: got %b want 1", busy); end
    bus.issue_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    nvec++; if (bus.out_data !== 16'd16) begin nerr++; $display("FAIL bp_second: got %0d want 16", $signed(bus.out_data)); end
    nvec++; if (bus.issue_ready !== 1'b1) begin nerr++; $display("FAIL bp_resume: got %b want 1", bus.issue_ready); end
    step();
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    for (int i = 0; i < N_TAPS; i++) pv[i] = 12;
    issue_group(-1);
    wait_valid(n);
    nvec++; if (n !== 3) begin nerr++; $display("FAIL bp_next_latency: got %0d want 3", n); end
    nvec++; if (bus.out_data !== 16'd24) begin nerr++; $display("FAIL bp_next_data: got %0d want 24", $signed(bus.out_data)); end
    step();
  endtask
  task automatic test_reset_mid();
    bus.issue_valid = 1'b1;
    op = 16'd100;
    repeat (5) step();
    bus.issue_valid = 1'b0;
    reset = 1'b0;
    #1;
    nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
    nvec++; if (bus.out_data !== 16'h0000) begin nerr++; $display("FAIL mid_data: got %h want 0000", bus.out_data); end
    nvec++; if (bus.issue_ready !== 1'b1) begin nerr++; $display("FAIL mid_ready: got %b want 1", bus.issue_ready); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL mid_busy: got %b want 0", busy); end
    repeat (2) step();
    reset = 1'b1;
    step();
    pv = '{1, 2, 3, 4, 5, 6, 7, 8};
    issue_group(-1);
    wait_valid(n);
    nvec++; if (n !== 3) begin nerr++; $display("FAIL fresh_latency: got %0d want 3", n); end
    nvec++; if (bus.out_data !== 16'd9) begin nerr++; $display("FAIL fresh_data: got %0d want 9", $signed(bus.out_data)); end
    step();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_round();
    test_stall();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
